// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU): quotient on div_loE, remainder on div_hiE.
// Define DIV_BYZERO_FAST_EN to finish a divide by zero one cycle after it is accepted.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_startE,
    input  logic             div_signedE,
    input  logic             div_annulE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic             div_stallE,
    output logic             div_readyE,
    output logic [WIDTH-1:0] div_hiE,
    output logic [WIDTH-1:0] div_loE
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_hi_fix;
    logic [WIDTH-1:0] w_lo_fix;

    assign w_accept = (r_state == S_IDLE) && div_startE && !div_annulE;
    assign w_a_neg  = div_signedE && srcaE[WIDTH-1];
    assign w_b_neg  = div_signedE && srcbE[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -srcaE : srcaE;
    assign w_b_mag  = w_b_neg ? -srcbE : srcbE;

    // Partial remainder is always below the divisor, so WIDTH bits hold it; the
    // shifted value needs one extra bit only for the compare.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_sub     = w_shift[WIDTH-1:0] - r_dvs;
    assign w_rem_nxt = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    assign w_lo_fix  = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_hi_fix  = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    assign div_stallE = w_accept || (r_state == S_BUSY);
    assign div_readyE = (r_state == S_DONE);
    assign div_hiE    = r_hi;
    assign div_loE    = r_lo;

    // NOTE: every register here, datapath included, is cleared by reset and
    // written with non-blocking assignments so all updates take effect together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_count <= CW'(WIDTH);
                        r_state <= S_BUSY;
`ifdef DIV_BYZERO_FAST_EN
                        // Zero divisor: all-ones magnitude quotient, dividend as remainder.
                        if (srcbE == '0) begin
                            r_count <= '0;
                            r_state <= S_DONE;
                            r_hi    <= srcaE;
                            r_lo    <= w_a_neg ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
                        end
`endif
                    end
                end
                S_BUSY: begin
                    if (div_annulE) begin
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem   <= w_rem_nxt;
                        r_quo   <= w_quo_nxt;
                        r_count <= r_count - 1'b1;
                        if (r_count == CW'(1)) begin
                            r_state <= S_DONE;
                            r_hi    <= w_hi_fix;
                            r_lo    <= w_lo_fix;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against an integer-arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_startE;
    logic        div_signedE;
    logic        div_annulE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        div_stallE;
    logic        div_readyE;
    logic [31:0] div_hiE;
    logic [31:0] div_loE;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_startE (div_startE),
        .div_signedE(div_signedE),
        .div_annulE (div_annulE),
        .srcaE      (srcaE),
        .srcbE      (srcbE),
        .div_stallE (div_stallE),
        .div_readyE (div_readyE),
        .div_hiE    (div_hiE),
        .div_loE    (div_loE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on magnitudes, zero divisor gives all ones / dividend.
    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, ma, mb, q, r;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        q  = (mb == 0) ? 64'hFFFF_FFFF : ma / mb;
        r  = (mb == 0) ? ma : ma % mb;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        el = q[31:0];
        eh = r[31:0];
    endfunction

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (div_readyE) pulses++;
        end
    endtask

    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit hold_start, input bit annul_done);
        logic [31:0] eh, el;
        int          exp_lat, got_lat, stall_bad, pulses;
        model(sgn, a, b, eh, el);
        exp_lat = 33;
`ifdef DIV_BYZERO_FAST_EN
        if (b == 32'd0) exp_lat = 1;
`endif
        @(posedge clk); #1;
        div_startE  = 1'b1;
        div_signedE = sgn;
        srcaE       = a;
        srcbE       = b;
        stall_bad   = 0;
        got_lat     = -1;
        @(negedge clk);
        if (!div_stallE) stall_bad++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (!hold_start) div_startE = 1'b0;
            div_annulE = annul_done && (k == exp_lat);
            @(negedge clk);
            if (div_readyE) begin
                got_lat = k;
                check({tag, "_stall_done"}, div_stallE, 1'b0);
                break;
            end
            if (!div_stallE) stall_bad++;
        end
        check({tag, "_lat"}, got_lat, exp_lat);
        check({tag, "_lo"}, div_loE, el);
        check({tag, "_hi"}, div_hiE, eh);
        check({tag, "_stall_busy"}, stall_bad, 0);
        last_hi = eh;
        last_lo = el;
        @(posedge clk); #1;
        div_startE = 1'b0;
        div_annulE = 1'b0;
        if (hold_start) begin
            count_pulses(40, pulses);
            check({tag, "_no_repeat"}, pulses, 0);
        end
    endtask

    initial begin
        int          pulses;
        logic [31:0] ra, rb;
        logic        rs;

        rst = 1'b1; div_startE = 1'b0; div_signedE = 1'b0; div_annulE = 1'b0;
        srcaE = '0; srcbE = '0;
        #1;
        check("rst_ready", div_readyE, 1'b0);
        check("rst_stall", div_stallE, 1'b0);
        check("rst_hi", div_hiE, 32'd0);
        check("rst_lo", div_loE, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_div("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
        do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
        do_div("hold_start", 1'b0, 32'd1000, 32'd33, 1'b1, 1'b0);
        do_div("hold_start_z", 1'b0, 32'd77, 32'd0, 1'b1, 1'b0);
        do_div("annul_done", 1'b1, 32'hFFFF_FC18, 32'd9, 1'b0, 1'b1);

        // Annul in BUSY at cycle 10.
        @(posedge clk); #1;
        div_startE = 1'b1; div_signedE = 1'b0; srcaE = 32'd1000; srcbE = 32'd3;
        @(posedge clk); #1;
        div_startE = 1'b0;
        pulses = 0;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            if (div_readyE) pulses++;
            @(posedge clk); #1;
        end
        div_annulE = 1'b1;
        @(negedge clk);
        check("annul_busy_stall", div_stallE, 1'b1);
        @(posedge clk); #1;
        div_annulE = 1'b0;
        @(negedge clk);
        if (div_readyE) pulses++;
        check("annul_idle_stall", div_stallE, 1'b0);
        check("annul_hi_keep", div_hiE, last_hi);
        check("annul_lo_keep", div_loE, last_lo);
        count_pulses(35, pulses);
        check("annul_no_pulse", pulses, 0);
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 1'b0, 1'b0);

        // Start with annul in IDLE is dropped.
        @(posedge clk); #1;
        div_startE = 1'b1; div_annulE = 1'b1; srcaE = 32'd50; srcbE = 32'd4;
        @(negedge clk);
        check("idle_annul_stall", div_stallE, 1'b0);
        @(posedge clk); #1;
        div_startE = 1'b0; div_annulE = 1'b0;
        count_pulses(36, pulses);
        check("idle_annul_no_pulse", pulses, 0);
        check("idle_annul_lo_keep", div_loE, last_lo);

        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'h8000_0000;
                3:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            rs = 1'($urandom_range(0, 1));
            do_div($sformatf("rnd%0d", n), rs, ra, rb, 1'b0, 1'b0);
        end

        // Async reset mid-BUSY.
        do_div("pre_rst", 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
        @(posedge clk); #1;
        div_startE = 1'b1; div_signedE = 1'b0; srcaE = 32'd12345; srcbE = 32'd7;
        @(posedge clk); #1;
        div_startE = 1'b0;
        repeat (14) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", div_readyE, 1'b0);
        check("arst_stall", div_stallE, 1'b0);
        check("arst_hi", div_hiE, 32'd0);
        check("arst_lo", div_loE, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        count_pulses(40, pulses);
        check("arst_no_pulse", pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
